// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu : load/store unit of the NPC core.
//
// Takes one decoded memory access at a time, issues it on a single-outstanding
// valid/ready memory port with byte-lane alignment and write strobes, and
// returns a sign/zero-extended load result (0 for stores) with a one-cycle
// completion pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned lh/lhu/sh (addr[0]) and lw/sw (addr[1:0]!=0) finish
//               immediately with out_err=1 and no memory request.
//   undefined : misaligned half/word accesses are forced to natural alignment.
//
// Parameters:
//   TIMEOUT : max cycles spent waiting for a response (0 disables watchdog)
//   AW      : address width
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake from decode
//   in_wen, in_func3          store select, RV32 load/store width code
//   in_addr, in_wdata         byte address, store data (rs2)
//   out_valid/out_rdata/out_err   completion pulse, load result, error flag
//   mem_req_valid/mem_req_ready   memory request handshake
//   mem_addr/mem_wen/mem_wdata/mem_wmask  word address, write, lane data, strobes
//   mem_resp_valid/mem_resp_rdata read data / write ack
// -----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wen,
    input  logic [2:0]    in_func3,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_wdata,
    output logic          out_valid,
    output logic [31:0]   out_rdata,
    output logic          out_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [31:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [31:0]   mem_resp_rdata
);

    // counter only needs to hold 0..TIMEOUT-1
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wen;
    logic [2:0]    r_func3;
    logic [1:0]    r_s;

    logic          r_in_ready;
    logic          r_out_valid;
    logic [31:0]   r_out_rdata;
    logic          r_out_err;
    logic          r_mem_req_valid;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_wen;
    logic [31:0]   r_mem_wdata;
    logic [7:0]    r_mem_wmask;

    logic          w_legal;
    logic          w_misalign;
    logic [1:0]    w_s;
    logic [7:0]    w_base;
    logic [31:0]   w_sdata;
    logic [7:0]    w_smask;
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic          w_timeout;

    // func3 legality: loads 0,1,2,4,5; stores 0,1,2
    always_comb begin
        w_legal = 1'b0;
        if (in_wen) begin
            w_legal = (in_func3[2] == 1'b0) && (in_func3[1:0] != 2'b11);
        end else begin
            case (in_func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((in_func3[1:0] == 2'b01) && in_addr[0]) ||
                        ((in_func3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // effective lane offset: halves/words snap to their natural alignment
    always_comb begin
        w_s    = 2'b00;
        w_base = 8'h0f;
        case (in_func3[1:0])
            2'b00: begin
                w_s    = in_addr[1:0];
                w_base = 8'h01;
            end
            2'b01: begin
                w_s    = {in_addr[1], 1'b0};
                w_base = 8'h03;
            end
            default: begin
                w_s    = 2'b00;
                w_base = 8'h0f;
            end
        endcase
    end

    assign w_sdata = in_wdata << {w_s, 3'b000};
    assign w_smask = w_base << w_s;

    // load extraction from the response word using the latched access shape
    assign w_word = mem_resp_rdata >> {r_s, 3'b000};

    always_comb begin
        w_load = w_word;
        case (r_func3)
            3'b000:  w_load = {{24{w_word[7]}}, w_word[7:0]};
            3'b100:  w_load = {24'h000000, w_word[7:0]};
            3'b001:  w_load = {{16{w_word[15]}}, w_word[15:0]};
            3'b101:  w_load = {16'h0000, w_word[15:0]};
            default: w_load = w_word;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && (32'(r_cnt) == (TIMEOUT - 32'd1));

    // access sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_wen           <= 1'b0;
            r_func3         <= 3'b000;
            r_s             <= 2'b00;
            r_in_ready      <= 1'b1;
            r_out_valid     <= 1'b0;
            r_out_rdata     <= 32'h0;
            r_out_err       <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= 32'h0;
            r_mem_wmask     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_wen      <= in_wen;
                        r_func3    <= in_func3;
                        r_s        <= w_s;
                        r_in_ready <= 1'b0;
                        if (!w_legal || w_misalign) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_err   <= 1'b1;
                            r_out_rdata <= 32'h0;
                        end else begin
                            r_state         <= S_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {in_addr[AW-1:2], 2'b00};
                            r_mem_wen       <= in_wen;
                            r_mem_wdata     <= in_wen ? w_sdata : 32'h0;
                            r_mem_wmask     <= in_wen ? w_smask : 8'h00;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b0;
                        r_out_rdata <= r_wen ? 32'h0 : w_load;
                    end else if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_out_err   <= 1'b0;
                    r_out_rdata <= 32'h0;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_rdata     = r_out_rdata;
    assign out_err       = r_out_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;

endmodule
